// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and its instruction queue.
package fetch_pkg;
  localparam int PC_W   = 13;
  localparam int INST_W = 16;
  localparam logic [3:0] OP_HALT = 4'b0000;

  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } entry_t;
endpackage

// File: rtl/fetch_queue.sv
// In-order instruction queue: DEPTH-entry synchronous FIFO with flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  entry_t                       push_data,
  input  logic                         pop,
  input  logic                         flush,
  output entry_t                       head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic            do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage is not reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: PC, request credit, stale-response discard, halt FSM.
// Optional FETCH_PERF_EN adds handshake and stall performance counters.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 13'h0000,
  parameter int              QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [PC_W-1:0]   id_pc,
  output logic [PC_W-1:0]   id_pc_plus2,
  output logic              halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);
  localparam int CW = $clog2(QDEPTH + 1);

  state_t          state, state_n;
  logic [PC_W-1:0] pc, resp_pc;
  logic [CW-1:0]   outstanding, out_n, discard, q_count;
  logic [CW:0]     in_use;
  logic            live, accept, redir_ok, handshake;
  logic            q_push, q_flush, q_full, q_empty;
  entry_t          q_head, q_in;

  assign in_use    = {1'b0, outstanding} + {1'b0, q_count};
  assign imem_req  = live && (state == RUN) && (in_use < (CW+1)'(QDEPTH));
  assign imem_addr = pc;
  assign accept    = imem_req & imem_ready;
  assign redir_ok  = redirect && (state != HALTED);
  assign out_n     = outstanding + CW'(accept) - CW'(imem_rvalid);

  // Kept responses arrive in order and back to back from the last redirect
  // target, so their PC is a running counter rather than a per-request record.
  assign q_in    = '{inst: imem_rdata, pc: resp_pc};
  assign q_push  = imem_rvalid && (discard == '0) && (state == RUN) && !redirect;
  assign q_flush = redir_ok || (state == HALTED);

  assign id_valid    = ~q_empty && (state != HALTED);
  assign handshake   = id_valid & id_ready;
  assign id_inst     = id_valid ? q_head.inst : '0;
  assign id_pc       = id_valid ? q_head.pc : '0;
  assign id_pc_plus2 = id_valid ? q_head.pc + PC_W'(2) : '0;
  assign halted      = (state == HALTED);

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .push_data (q_in),
    .pop       (handshake),
    .flush     (q_flush),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // NOTE: next state takes its default first so no path through the case infers a latch.
  always_comb begin
    state_n = state;
    case (state)
      RUN:       if (q_push && imem_rdata[15:12] == OP_HALT) state_n = HALT_PEND;
      HALT_PEND: begin
        if (redirect) state_n = RUN;
        else if (handshake && q_head.inst[15:12] == OP_HALT) state_n = HALTED;
      end
      HALTED:    state_n = HALTED;
      default:   state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      live        <= 1'b0;
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_n;
      live        <= 1'b1;
      outstanding <= out_n;
      if (redir_ok) begin
        pc      <= redirect_pc;
        resp_pc <= redirect_pc;
        discard <= out_n;
      end else begin
        if (accept)                          pc      <= pc + PC_W'(2);
        if (q_push)                          resp_pc <= resp_pc + PC_W'(2);
        if (imem_rvalid && discard != '0)    discard <= discard - 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (handshake)              perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (id_valid && !id_ready)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(q_push && q_full && !handshake && !q_flush));
endmodule

// File: tb/tb_fetch.sv
// Randomised bench for fetch against a queue-based model of the stage's rules.
module tb_fetch;
  import fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req, imem_ready, imem_rvalid, redirect, id_valid, id_ready, halted;
  logic [12:0] imem_addr, redirect_pc, id_pc, id_pc_plus2;
  logic [15:0] imem_rdata, id_inst;

  logic        w_req, w_rvalid, w_id_valid, w_halted;
  logic [12:0] w_addr, w_id_pc, w_id_pc2;
  logic [15:0] w_rdata, w_id_inst;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, w_perf_fetch, w_perf_stall;
`endif

  fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst),
    .id_pc(id_pc), .id_pc_plus2(id_pc_plus2), .halted(halted)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  fetch #(.RESET_PC(13'h1FFE)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect(1'b0), .redirect_pc(13'h0000),
    .id_valid(w_id_valid), .id_ready(1'b1), .id_inst(w_id_inst),
    .id_pc(w_id_pc), .id_pc_plus2(w_id_pc2), .halted(w_halted)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(w_perf_fetch), .perf_stall_cnt(w_perf_stall)
`endif
  );

  typedef struct {
    logic [12:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        mem_q[$];
  entry_t      exp_q[$];
  logic [12:0] m_pc;
  bit          m_live, m_pend, m_halted, halt_en;
  bit          w_pend;
  logic [12:0] w_pend_addr;
  int          cyc, checks, failures, m_fetch, m_stall;

  function automatic logic [15:0] mem_word(input logic [12:0] a);
    if (halt_en && a == 13'h0004) return 16'h0ABC;
    return {3'b101, a};
  endfunction

  function automatic bit model_req();
    return m_live && !m_pend && !m_halted && (mem_q.size() + exp_q.size() < 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic compare();
    entry_t h;
    bit     r;
    r = model_req();
    check("imem_req", imem_req, r);
    if (r) check("imem_addr", imem_addr, m_pc);
    check("id_valid", id_valid, exp_q.size() != 0);
    check("halted", halted, m_halted);
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check("id_inst", id_inst, h.inst);
      check("id_pc", id_pc, h.pc);
      check("id_pc_plus2", id_pc_plus2, 13'(h.pc + 13'd2));
    end else begin
      check("id_inst_idle", id_inst, 16'h0000);
      check("id_pc_idle", id_pc, 13'h0000);
    end
`ifdef FETCH_PERF_EN
    check("perf_fetch", perf_fetch_cnt, m_fetch);
    check("perf_stall", perf_stall_cnt, m_stall);
`endif
  endtask

  // One clock: compare at the negedge, drive inputs, advance the model, clock.
  task automatic cycle(input bit rdy, input bit rv_ok, input bit idr,
                       input bit redir, input logic [12:0] rpc);
    bit          r, rv, w_acc;
    req_t        rq;
    entry_t      popped;
    logic [15:0] word;
    logic [12:0] w_acc_addr;
    compare();
    r  = model_req();
    rv = rv_ok && mem_q.size() != 0 && mem_q[0].due <= cyc;
    imem_ready  = rdy;
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(mem_q[0].addr) : 16'($urandom);
    id_ready    = idr;
    redirect    = redir;
    redirect_pc = rpc;
    w_rvalid    = w_pend;
    w_rdata     = mem_word(w_pend_addr);
    w_acc       = w_req;
    w_acc_addr  = w_addr;

    if (exp_q.size() != 0 && !idr) m_stall++;
    if (exp_q.size() != 0 && idr) begin
      popped = exp_q.pop_front();
      m_fetch++;
      if (m_pend && popped.inst[15:12] == 4'h0 && !redir) begin
        m_pend   = 1'b0;
        m_halted = 1'b1;
      end
    end
    if (rv) begin
      rq = mem_q.pop_front();
      if (!rq.stale && !redir && !m_pend && !m_halted) begin
        word = mem_word(rq.addr);
        exp_q.push_back('{inst: word, pc: rq.addr});
        if (word[15:12] == 4'h0) m_pend = 1'b1;
      end
    end
    if (r && rdy) begin
      mem_q.push_back('{addr: m_pc, due: cyc + 1, stale: 1'b0});
      m_pc = m_pc + 13'd2;
    end
    if (redir && !m_halted) begin
      exp_q.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      m_pc   = rpc;
      m_pend = 1'b0;
    end
    m_live = 1'b1;

    @(posedge clk);
    cyc++;
    w_pend      = w_acc;
    w_pend_addr = w_acc_addr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    id_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    w_rvalid = 1'b0; w_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 13'h0000);
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_id_inst", id_inst, 16'h0000);
    check("rst_id_pc2", id_pc_plus2, 13'h0000);
    check("rst_halted", halted, 1'b0);
    check("rst_wrap_addr", w_addr, 13'h1FFE);
    mem_q.delete();
    exp_q.delete();
    m_pc = 13'h0000; m_live = 0; m_pend = 0; m_halted = 0;
    m_fetch = 0; m_stall = 0;
    w_pend = 0; w_pend_addr = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    bit seen, seen2;
    checks = 0; failures = 0; cyc = 0; halt_en = 0;

    // Streaming with 1-cycle memory, plus the wrapping instance.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      if (k == 1) begin
        check("wrap_req0", w_req, 1'b1);
        check("wrap_addr0", w_addr, 13'h1FFE);
      end
      if (k == 2) check("wrap_addr1", w_addr, 13'h0000);
      if (k == 3) begin
        check("wrap_id_pc", w_id_pc, 13'h1FFE);
        check("wrap_id_pc2", w_id_pc2, 13'h0000);
      end
      cycle(1, 1, 1, 0, 13'h0);
    end

    // Decode backpressure for 5 cycles, then release.
    do_reset();
    for (int k = 0; k < 30; k++) begin
      if (k == 12) check("bp_req_low", imem_req, 1'b0);
      cycle(1, 1, !(k >= 8 && k < 13), 0, 13'h0);
    end

    // Redirect with two requests in flight.
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1, 0, 1, 0, 13'h0);
    check("redir_inflight_req", imem_req, 1'b0);
    cycle(1, 0, 1, 1, 13'h0100);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (id_valid) begin
        check("redir_first_pc", id_pc, 13'h0100);
        seen = 1;
      end else cycle(1, 1, 1, 0, 13'h0);
    end
    check("redir_seen", seen, 1'b1);

    // Halt word at 0x0004, then redirect attempts while halted.
    halt_en = 1;
    do_reset();
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cycle(1, 1, 1, 0, 13'h0);
      if (halted) seen = 1;
    end
    check("halt_reached", seen, 1'b1);
    for (int k = 0; k < 10; k++) cycle(1, 1, 1, k == 3, 13'h0200);
    check("halt_sticky", halted, 1'b1);
    check("halt_no_req", imem_req, 1'b0);

    // Redirect while the halt word waits at the head of the queue.
    do_reset();
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      if (exp_q.size() != 0 && exp_q[0].pc == 13'h0004) seen = 1;
      else cycle(1, 1, 1, 0, 13'h0);
    end
    check("hp_head_pc", id_pc, 13'h0004);
    cycle(1, 1, 0, 0, 13'h0);
    cycle(1, 1, 0, 1, 13'h0040);
    seen2 = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1, 1, 1, 0, 13'h0);
      if (id_valid && id_pc == 13'h0040) seen2 = 1;
    end
    check("hp_resume", seen2, 1'b1);
    check("hp_not_halted", halted, 1'b0);

    // Random traffic in segments, each starting from reset.
    for (int seg = 0; seg < 6; seg++) begin
      halt_en = ($urandom_range(0, 2) == 0);
      do_reset();
      for (int k = 0; k < 500; k++) begin
        logic [12:0] rnd, rpc;
        int          sel;
        rnd = 13'($urandom);
        sel = $urandom_range(0, 3);
        rpc = (sel == 0) ? 13'h0000 : (sel == 1) ? 13'h1FFC : {rnd[12:1], 1'b0};
        cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
              $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 4, rpc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
